// File: rtl/m_seq_adder.sv
// rtl/m_seq_adder.sv - multi-cycle adder/subtractor processing one CHUNK-bit slice per clock
//
// Purpose: adds or subtracts two WIDTH-bit operands, CHUNK bits per cycle,
// LSB slice first, with the carry registered between slices. Latency from
// the accepting edge to the done pulse is WIDTH/CHUNK cycles.
//
// Ports:
//   clk    - clock, rising edge active
//   rst_n  - synchronous active-low reset
//   start  - operation request, accepted in IDLE or DONE
//   A, B   - WIDTH-bit operands
//   Cin    - carry-in (add mode only)
//   sub    - 0 = add, 1 = subtract (A + ~B + 1)
//   busy   - operation in progress
//   done   - one-cycle result-valid pulse
//   S      - registered sum/difference, held until the next done
//   Cout   - carry out of the MSB (subtract: 1 = no borrow)
//   Ovf    - signed two's-complement overflow

module m_seq_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK:0]   slice_sum;
    logic [WIDTH-1:0] acc_next;

    // Operands shift right each cycle so the current slice is always the
    // low CHUNK bits; result slices enter the accumulator from the top so
    // that after NCH cycles the accumulator holds the full result in place.
    always_comb begin
        slice_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, carry_q};
        acc_next  = (acc_q >> CHUNK)
                  | (WIDTH'(slice_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    // Subtraction is folded into the latched operand:
                    // A - B = A + ~B + 1, so Cin plays no part.
                    a_d     = A;
                    b_d     = sub ? ~B : B;
                    carry_d = sub ? 1'b1 : Cin;
                    a_msb_d = A[WIDTH-1];
                    b_msb_d = sub ? ~B[WIDTH-1] : B[WIDTH-1];
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = slice_sum[CHUNK];
                acc_d   = acc_next;
                idx_d   = idx_q + IW'(1);
                if (idx_q == LAST_IDX) begin
                    s_d     = acc_next;
                    cout_d  = slice_sum[CHUNK];
                    ovf_d   = (a_msb_q == b_msb_q) && (acc_next[WIDTH-1] != a_msb_q);
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign S    = s_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;

endmodule
